// File: rtl/branch_pc_unit.sv
// Program counter and branch resolution: retires one instruction per cycle,
// tracks ALU flags, resolves branches/jumps, and parks in HALT until resumed.
module branch_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        resume,
  input  logic [2:0]  opcode,
  input  logic [3:0]  fcode,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_sign,
  input  logic [31:0] br_offset,
  input  logic [31:0] rs_value,
  output logic [31:0] pc,
  output logic        flag_c,
  output logic        flag_z,
  output logic        flag_s,
  output logic        branch_taken,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  flags_q, flags_d;  // {c, z, s}
  logic        bt_q, bt_d;
  logic        lwe_q, lwe_d;
  logic [31:0] ld_q, ld_d;

  logic [31:0] pc_inc, br_tgt;
  logic        retire, taken;

  assign pc_inc = pc_q + 32'd4;
  assign br_tgt = (pc_inc + br_offset) & 32'hFFFF_FFFC;
  assign retire = (state_q == RUN) && instr_valid && !stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    bt_d    = 1'b0;
    lwe_d   = 1'b0;
    ld_d    = ld_q;
    taken   = 1'b0;
    case (state_q)
      RUN: begin
        if (retire) begin
          pc_d = pc_inc;
          case (opcode)
            3'b000: if (fcode <= 4'd9) flags_d = {alu_carry, alu_zero, alu_sign};
            3'b001: if (fcode <= 4'd1) flags_d = {alu_carry, alu_zero, alu_sign};
            3'b101: begin
              // Conditional on live ALU flags, not the registered ones.
              case (fcode)
                4'd0:    taken = alu_sign;
                4'd1:    taken = alu_zero;
                4'd2:    taken = !alu_zero;
                default: taken = 1'b0;
              endcase
              if (taken) pc_d = br_tgt;
            end
            3'b011: begin
              case (fcode)
                4'd0, 4'd1: taken = 1'b1;
                4'd2:       taken = flags_q[2];
                4'd3:       taken = !flags_q[2];
                default:    taken = 1'b0;
              endcase
              if (taken) pc_d = br_tgt;
              if (fcode == 4'd1) begin
                lwe_d = 1'b1;
                ld_d  = pc_inc;
              end
            end
            3'b100: begin
              if (fcode == 4'd0) begin
                taken = 1'b1;
                pc_d  = rs_value & 32'hFFFF_FFFC;
              end
            end
            3'b111: begin
              pc_d    = pc_q;
              state_d = HALT;
            end
            default: ;
          endcase
          bt_d = taken;
        end
      end
      HALT: begin
        if (resume) begin
          state_d = RUN;
          pc_d    = pc_inc;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      flags_q <= 3'b000;
      bt_q    <= 1'b0;
      lwe_q   <= 1'b0;
      ld_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      bt_q    <= bt_d;
      lwe_q   <= lwe_d;
      ld_q    <= ld_d;
    end
  end

  assign pc           = pc_q;
  assign {flag_c, flag_z, flag_s} = flags_q;
  assign branch_taken = bt_q;
  assign link_we      = lwe_q;
  assign link_data    = ld_q;
  assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed and randomized checks of branch_pc_unit against a behavioural model.
module tb_branch_pc_unit;

  logic        clk, rst, instr_valid, stall, resume;
  logic [2:0]  opcode;
  logic [3:0]  fcode;
  logic        alu_carry, alu_zero, alu_sign;
  logic [31:0] br_offset, rs_value;
  logic [31:0] pc, link_data;
  logic        flag_c, flag_z, flag_s, branch_taken, link_we, halted;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  logic [31:0] m_pc, m_ld;
  logic        m_c, m_z, m_s, m_halt, m_bt, m_lwe;

  branch_pc_unit dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .stall(stall), .resume(resume),
    .opcode(opcode), .fcode(fcode), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_sign(alu_sign), .br_offset(br_offset), .rs_value(rs_value), .pc(pc),
    .flag_c(flag_c), .flag_z(flag_z), .flag_s(flag_s), .branch_taken(branch_taken),
    .link_we(link_we), .link_data(link_data), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".flags"}, {29'd0, flag_c, flag_z, flag_s}, {29'd0, m_c, m_z, m_s});
    chk({tag, ".bt"}, {31'd0, branch_taken}, {31'd0, m_bt});
    chk({tag, ".lwe"}, {31'd0, link_we}, {31'd0, m_lwe});
    chk({tag, ".ld"}, link_data, m_ld);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halt});
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ld = 32'h0;
    {m_c, m_z, m_s} = 3'b000;
    m_halt = 1'b0; m_bt = 1'b0; m_lwe = 1'b0;
  endtask

  // Next state from the instruction-set rules, using the inputs currently driven.
  task automatic model_next();
    logic [31:0] seq, tgt;
    logic        tk, lnk;
    seq = m_pc + 32'd4;
    tk = 1'b0; lnk = 1'b0; tgt = seq;
    if (m_halt) begin
      if (resume) begin m_halt = 1'b0; m_pc = seq; end
    end else if (instr_valid && !stall) begin
      case (opcode)
        3'd0: if (fcode <= 9) {m_c, m_z, m_s} = {alu_carry, alu_zero, alu_sign};
        3'd1: if (fcode <= 1) {m_c, m_z, m_s} = {alu_carry, alu_zero, alu_sign};
        3'd5: begin
          tk  = (fcode == 0 && alu_sign) || (fcode == 1 && alu_zero) || (fcode == 2 && !alu_zero);
          tgt = seq + br_offset;
        end
        3'd3: begin
          tk  = (fcode == 0) || (fcode == 1) || (fcode == 2 && m_c) || (fcode == 3 && !m_c);
          lnk = (fcode == 1);
          tgt = seq + br_offset;
        end
        3'd4: begin tk = (fcode == 0); tgt = rs_value; end
        default: ;
      endcase
      if (opcode == 3'd7) begin
        m_halt = 1'b1;
      end else begin
        m_pc = tk ? {tgt[31:2], 2'b00} : seq;
      end
      if (lnk) m_ld = seq;
    end
    m_bt  = tk;
    m_lwe = lnk;
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] fc, input logic c, input logic z,
                       input logic s, input logic [31:0] off, input logic [31:0] rs,
                       input logic v, input logic st, input logic rsm);
    opcode = op; fcode = fc; alu_carry = c; alu_zero = z; alu_sign = s;
    br_offset = off; rs_value = rs; instr_valid = v; stall = st; resume = rsm;
  endtask

  task automatic step(input string tag);
    model_next();
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic jump_to(input logic [31:0] a);
    drive(3'd4, 4'd0, 0, 0, 0, 0, a, 1, 0, 0);
    step("jr_setup");
  endtask

  initial begin
    drive(3'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    #12;
    chk_all("reset");
    drive(3'd0, 4'd3, 0, 0, 0, 0, 0, 1, 0, 0);
    rst = 1'b0;

    // three ALU retires straight out of reset
    step("alu0"); chk("alu0.lit", pc, 32'h4);
    step("alu1"); chk("alu1.lit", pc, 32'h8);
    step("alu2"); chk("alu2.lit", pc, 32'hC);

    // bz taken / not taken
    jump_to(32'h10);
    drive(3'd5, 4'd1, 0, 1, 0, 32'h20, 0, 1, 0, 0);
    step("bz_t"); chk("bz_t.lit", pc, 32'h34); chk("bz_t.bt", {31'd0, branch_taken}, 32'd1);
    jump_to(32'h10);
    drive(3'd5, 4'd1, 0, 0, 0, 32'h20, 0, 1, 0, 0);
    step("bz_n"); chk("bz_n.lit", pc, 32'h14);

    // carry flag then bcy / bncy
    drive(3'd0, 4'd0, 1, 0, 0, 0, 0, 1, 0, 0);
    step("add_c"); chk("add_c.lit", {31'd0, flag_c}, 32'd1);
    jump_to(32'h40);
    drive(3'd3, 4'd2, 0, 0, 0, 32'h8, 0, 1, 0, 0);
    step("bcy"); chk("bcy.lit", pc, 32'h4C);
    jump_to(32'h40);
    drive(3'd3, 4'd3, 0, 0, 0, 32'h8, 0, 1, 0, 0);
    step("bncy"); chk("bncy.lit", pc, 32'h44);

    // bl with negative offset, then misaligned jr
    jump_to(32'h100);
    drive(3'd3, 4'd1, 0, 0, 0, 32'hFFFF_FF00, 0, 1, 0, 0);
    step("bl"); chk("bl.lit", pc, 32'h4); chk("bl.ld", link_data, 32'h104);
    drive(3'd0, 4'd3, 0, 0, 0, 0, 0, 1, 0, 0);
    step("bl_after"); chk("bl_after.lwe", {31'd0, link_we}, 32'd0);
    drive(3'd4, 4'd0, 0, 0, 0, 0, 32'h203, 1, 0, 0);
    step("jr"); chk("jr.lit", pc, 32'h200);

    // halt, hold under valid, resume
    jump_to(32'h50);
    drive(3'd7, 4'd0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("halt"); chk("halt.lit", {31'd0, halted}, 32'd1);
    drive(3'd5, 4'd1, 0, 1, 0, 32'h20, 0, 1, 0, 0);
    step("halt_hold0"); step("halt_hold1"); chk("halt_hold.lit", pc, 32'h50);
    drive(3'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("resume"); chk("resume.lit", pc, 32'h54);

    // stall with a taken bz
    drive(3'd5, 4'd1, 1, 1, 1, 32'h20, 0, 1, 1, 0);
    step("stall"); chk("stall.lit", pc, 32'h54);

    // async reset in HALT
    drive(3'd7, 4'd0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("halt2");
    rst = 1'b1;
    #1;
    model_reset();
    chk_all("rst_halt");
    #2;
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom), 4'($urandom_range(0, 4)), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom & 32'h0000_00FF) - 32'h80, $urandom,
            ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
